branch_hazard_ctrl: RTL and testbench
=====================================

# branch_hazard_ctrl

Sequences the ID-stage branch/jump resolution path of the RV32I pipeline. Branches, JAL and JALR resolve in ID. This block detects operand hazards for the ID comparator and target adder, then stalls IF/ID and bubbles ID/EX for the required number of cycles. It drives the comparator operand forwarding selects, and on a taken branch or jump it issues the PC redirect and the IF/ID flush. It sits between the pipeline registers, the hazard inputs from EX/MEM/WB, and the branch generator's `PC_source`/`Branch_target` outputs.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk_i`  in  1  pipeline clock; all state updates on rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `ID_Valid_i`  in  1  ID holds a real instruction (0 = bubble).
- `ID_BranchE_i`, `ID_JumpE_i`, `ID_isJALR_i`  in  1 each  ID control-flow decode.
- `ID_Rs1Addr_i`, `ID_Rs2Addr_i`  in  5 each  ID source registers.
- `EX_RdAddr_i`  in  5  EX-stage destination register.
- `EX_RegWrite_i`, `EX_MemRead_i`  in  1 each  EX-stage write-enable and load flag.
- `MEM_RdAddr_i`  in  5  MEM-stage destination register.
- `MEM_RegWrite_i`, `MEM_MemRead_i`  in  1 each  MEM-stage write-enable and load flag.
- `WB_RdAddr_i`  in  5  WB-stage destination register.
- `WB_RegWrite_i`  in  1  WB-stage write-enable.
- `Mem_stall_i`  in  1  global pipeline freeze from the memory system.
- `PC_source_i`  in  1  taken indication from the branch generator (1 = branch/jump taken).
- `Branch_target_i`  in  32  target from the branch generator.
- `Fwd_Rs1_sel_o`, `Fwd_Rs2_sel_o`  out  2 each  comparator operand source: 0 = regfile, 1 = MEM ALU result, 2 = WB data.
- `Stall_IF_o`, `Stall_ID_o`  out  1 each  hold PC and IF/ID.
- `Bubble_EX_o`  out  1  load NOP into ID/EX.
- `PC_load_o`  out  1  load `PC_target_o` into PC.
- `PC_target_o`  out  32  redirect address.
- `Flush_IFID_o`  out  1  kill the wrong-path instruction in IF/ID.
- `Branch_count_o`, `Taken_count_o`, `Stall_cycles_o`  out  32 each  performance counters; present only under `BRANCH_PERF_CNT_EN`.

## Operation
- `cf = ID_Valid_i & (ID_BranchE_i | ID_JumpE_i)`.
- Source usage:
  - branch (`ID_BranchE_i`): uses rs1 and rs2.
  - JALR: uses rs1 only.
  - JAL: uses no sources.
  - A register address of 0 never matches.
- Stall need `need` (0..2), taking the maximum of the applicable terms:
  - EX load match (`EX_RegWrite_i & EX_MemRead_i`): 2.
  - EX non-load match: 1.
  - MEM load match: 1.
  - otherwise: 0.
- Forwarding selects (per source, combinational, independent of `cf`):
  - 1 if MEM non-load write matches.
  - else 2 if WB write matches.
  - else 0.
  - MEM has priority over WB.
- FSM states: `RUN`, `STALL`. Stall counter `cnt` is 2 bits.
  - `RUN`, `cf & need != 0`:
    - assert `Stall_IF_o`, `Stall_ID_o`, `Bubble_EX_o`;
    - `cnt <= need - 1`;
    - if `need == 1`, stay in `RUN`; else go to `STALL`.
  - `STALL`: assert the same three outputs; `cnt <= cnt - 1`; when `cnt == 1`, go to `RUN`.
  - `RUN`, `cf & need == 0` and `PC_source_i == 1`:
    - `PC_load_o = 1`, `PC_target_o = Branch_target_i`, `Flush_IFID_o = 1`, all in the same cycle.
  - `RUN`, `cf & need == 0` and `PC_source_i == 0`: no action; fall through.
  - Hazard is re-evaluated in `RUN` every cycle.
- `PC_target_o`: equals `Branch_target_i` whenever `PC_load_o` is 1; otherwise 0.
- `Mem_stall_i == 1` (freeze):
  - state, `cnt` and counters hold;
  - `PC_load_o`, `Flush_IFID_o` and `Bubble_EX_o` are forced to 0;
  - `Stall_IF_o` and `Stall_ID_o` keep their state-derived values.

## Timing
- Redirect latency:
  - 0 cycles after the hazard clears (combinational from ID inputs).
  - Taken-branch penalty is 1 flushed slot.
- Stall cycles: EX load = 2, EX ALU = 1, MEM load = 1.
- Reset (`rst_i` high at a clock edge):
  - next state `RUN`, `cnt = 0`, counters = 0.
  - While `rst_i == 1`, all outputs are 0 (`PC_target_o = 0`, selects = 0).
- Reset mid-`STALL`: the next cycle is `RUN` with no stall carried over.
- `ID_Valid_i == 0`: no stall, no redirect, no counter update.
- Simultaneous hazard and `PC_source_i == 1`: stall wins; no redirect until `need == 0`.

## Configuration
- Macro: `BRANCH_PERF_CNT_EN`.
- Defined:
  - `Branch_count_o` increments once per resolved `cf` instruction (the cycle `need == 0` and not frozen).
  - `Taken_count_o` increments on each `PC_load_o`.
  - `Stall_cycles_o` increments on each unfrozen cycle with `Stall_ID_o == 1`.
  - All three counters saturate at `0xFFFFFFFF` and clear on reset.
- Undefined:
  - the three counter ports and registers are absent;
  - all other behaviour is identical.

## Test plan
- BEQ rs1=x5 while EX writes x5 via `lw` (`EX_MemRead_i = 1`) -> `Stall_ID_o` and `Bubble_EX_o` high for exactly 2 cycles, then `PC_load_o = 1` with `PC_target_o = Branch_target_i` (e.g. `0x0000_0100`) and `Flush_IFID_o = 1` in cycle 3.
- BNE rs2=x7 with MEM ALU writing x7 and WB also writing x7 -> no stall, `Fwd_Rs2_sel_o = 1`, redirect same cycle if `PC_source_i = 1`.
- JAL with EX writing x1 via load -> no stall (no sources used), `PC_load_o = 1` immediately.
- JALR rs1=x0 while EX writes x0 -> no stall, `Fwd_Rs1_sel_o = 0`.
- `rst_i` asserted in the first `STALL` cycle of a 2-cycle load stall -> next cycle `RUN`, all outputs 0 during reset, `cnt = 0`; with `BRANCH_PERF_CNT_EN`, counters read 0.
- `Mem_stall_i = 1` for 3 cycles during `STALL` with `cnt = 1` -> state held, `Stall_ID_o` stays 1, `Bubble_EX_o = 0`; after release, 1 more stall cycle, then the redirect; `Stall_cycles_o` increases by exactly 2.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// ============================================================================
// branch_hazard_ctrl: ID-stage branch/jump hazard stall, operand forwarding
// select and taken-redirect sequencing for the RV32I pipeline.
// Optional perf counters enabled by macro BRANCH_PERF_CNT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_hazard_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ID_Valid_i,
    input  logic        ID_BranchE_i,
    input  logic        ID_JumpE_i,
    input  logic        ID_isJALR_i,
    input  logic [4:0]  ID_Rs1Addr_i,
    input  logic [4:0]  ID_Rs2Addr_i,
    input  logic [4:0]  EX_RdAddr_i,
    input  logic        EX_RegWrite_i,
    input  logic        EX_MemRead_i,
    input  logic [4:0]  MEM_RdAddr_i,
    input  logic        MEM_RegWrite_i,
    input  logic        MEM_MemRead_i,
    input  logic [4:0]  WB_RdAddr_i,
    input  logic        WB_RegWrite_i,
    input  logic        Mem_stall_i,
    input  logic        PC_source_i,
    input  logic [31:0] Branch_target_i,
    output logic [1:0]  Fwd_Rs1_sel_o,
    output logic [1:0]  Fwd_Rs2_sel_o,
    output logic        Stall_IF_o,
    output logic        Stall_ID_o,
    output logic        Bubble_EX_o,
    output logic        PC_load_o,
    output logic [31:0] PC_target_o,
    output logic        Flush_IFID_o
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0] Branch_count_o,
    output logic [31:0] Taken_count_o,
    output logic [31:0] Stall_cycles_o
`endif
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] cnt_q, cnt_d;

    logic       cf;
    logic       use_rs1, use_rs2;
    logic       rs1_nz, rs2_nz;
    logic       ex_match, mem_match;
    logic [1:0] need;
    logic       stall;
    logic       redirect;

    assign cf      = ID_Valid_i & (ID_BranchE_i | ID_JumpE_i);
    assign use_rs1 = ID_BranchE_i | (ID_JumpE_i & ID_isJALR_i);
    assign use_rs2 = ID_BranchE_i;
    assign rs1_nz  = (ID_Rs1Addr_i != 5'd0);
    assign rs2_nz  = (ID_Rs2Addr_i != 5'd0);

    // Only sources the instruction actually reads can create a hazard.
    assign ex_match  = EX_RegWrite_i &
                       ((use_rs1 & rs1_nz & (EX_RdAddr_i == ID_Rs1Addr_i)) |
                        (use_rs2 & rs2_nz & (EX_RdAddr_i == ID_Rs2Addr_i)));
    assign mem_match = MEM_RegWrite_i &
                       ((use_rs1 & rs1_nz & (MEM_RdAddr_i == ID_Rs1Addr_i)) |
                        (use_rs2 & rs2_nz & (MEM_RdAddr_i == ID_Rs2Addr_i)));

    always_comb begin
        need = 2'd0;
        if (ex_match && EX_MemRead_i) begin
            need = 2'd2;
        end else if (ex_match || (mem_match && MEM_MemRead_i)) begin
            need = 2'd1;
        end
    end

    always_comb begin
        Fwd_Rs1_sel_o = 2'd0;
        Fwd_Rs2_sel_o = 2'd0;
        if (!rst_i) begin
            if (rs1_nz && MEM_RegWrite_i && !MEM_MemRead_i && (MEM_RdAddr_i == ID_Rs1Addr_i)) begin
                Fwd_Rs1_sel_o = 2'd1;
            end else if (rs1_nz && WB_RegWrite_i && (WB_RdAddr_i == ID_Rs1Addr_i)) begin
                Fwd_Rs1_sel_o = 2'd2;
            end
            if (rs2_nz && MEM_RegWrite_i && !MEM_MemRead_i && (MEM_RdAddr_i == ID_Rs2Addr_i)) begin
                Fwd_Rs2_sel_o = 2'd1;
            end else if (rs2_nz && WB_RegWrite_i && (WB_RdAddr_i == ID_Rs2Addr_i)) begin
                Fwd_Rs2_sel_o = 2'd2;
            end
        end
    end

    assign stall    = !rst_i && ((state_q == STALL) || (cf && (need != 2'd0)));
    assign redirect = !rst_i && !Mem_stall_i && (state_q == RUN) && cf &&
                      (need == 2'd0) && PC_source_i;

    assign Stall_IF_o   = stall;
    assign Stall_ID_o   = stall;
    assign Bubble_EX_o  = stall & ~Mem_stall_i;
    assign PC_load_o    = redirect;
    assign Flush_IFID_o = redirect;
    assign PC_target_o  = redirect ? Branch_target_i : 32'd0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!Mem_stall_i) begin
            case (state_q)
                RUN: begin
                    if (cf && (need != 2'd0)) begin
                        cnt_d   = need - 2'd1;
                        state_d = (need == 2'd2) ? STALL : RUN;
                    end
                end
                STALL: begin
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_q, taken_cnt_q, stall_cnt_q;
    logic        resolved;

    assign resolved = !Mem_stall_i && (state_q == RUN) && cf && (need == 2'd0);

    // Counters saturate rather than wrap so long runs never read as short ones.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            branch_cnt_q <= 32'd0;
            taken_cnt_q  <= 32'd0;
            stall_cnt_q  <= 32'd0;
        end else begin
            if (resolved && (branch_cnt_q != 32'hFFFF_FFFF)) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (redirect && (taken_cnt_q != 32'hFFFF_FFFF)) begin
                taken_cnt_q <= taken_cnt_q + 32'd1;
            end
            if (stall && !Mem_stall_i && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign Branch_count_o = rst_i ? 32'd0 : branch_cnt_q;
    assign Taken_count_o  = rst_i ? 32'd0 : taken_cnt_q;
    assign Stall_cycles_o = rst_i ? 32'd0 : stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_hazard_ctrl.sv
// ============================================================================
// tb_branch_hazard_ctrl: table-driven directed bench for branch_hazard_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        valid, br, jmp, jalr;
    logic [4:0]  rs1, rs2, exrd, memrd, wbrd;
    logic        exw, exm, memw, memm, wbw;
    logic        ms, pcs;
    logic [31:0] tgt;
    logic [1:0]  f1, f2;
    logic        stall_if, stall_id, bubble, pc_load, flush;
    logic [31:0] pc_target;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] br_cnt, tk_cnt, st_cnt;
    logic [31:0] st_base, tk_base;
`endif

    typedef struct {
        logic        ms, v, br, jmp, jalr;
        logic [4:0]  rs1, rs2, exrd;
        logic        exw, exm;
        logic [4:0]  memrd;
        logic        memw, memm;
        logic [4:0]  wbrd;
        logic        wbw, pcs;
        logic [31:0] tgt;
        logic        e_st, e_bub, e_ld, e_fl;
        logic [1:0]  e_f1, e_f2;
        logic [31:0] e_tgt;
    } vec_t;

    vec_t tbl [13];
    int   nvec  = 0;
    int   nfail = 0;

    branch_hazard_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .ID_Valid_i     (valid),
        .ID_BranchE_i   (br),
        .ID_JumpE_i     (jmp),
        .ID_isJALR_i    (jalr),
        .ID_Rs1Addr_i   (rs1),
        .ID_Rs2Addr_i   (rs2),
        .EX_RdAddr_i    (exrd),
        .EX_RegWrite_i  (exw),
        .EX_MemRead_i   (exm),
        .MEM_RdAddr_i   (memrd),
        .MEM_RegWrite_i (memw),
        .MEM_MemRead_i  (memm),
        .WB_RdAddr_i    (wbrd),
        .WB_RegWrite_i  (wbw),
        .Mem_stall_i    (ms),
        .PC_source_i    (pcs),
        .Branch_target_i(tgt),
        .Fwd_Rs1_sel_o  (f1),
        .Fwd_Rs2_sel_o  (f2),
        .Stall_IF_o     (stall_if),
        .Stall_ID_o     (stall_id),
        .Bubble_EX_o    (bubble),
        .PC_load_o      (pc_load),
        .PC_target_o    (pc_target),
        .Flush_IFID_o   (flush)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .Branch_count_o (br_cnt),
        .Taken_count_o  (tk_cnt),
        .Stall_cycles_o (st_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Argument order: ms,v,br,jmp,jalr, rs1,rs2, exrd,exw,exm, memrd,memw,memm,
    // wbrd,wbw, pcs,tgt, then expected st,bub,ld,fl,f1,f2,tgt.
    function automatic vec_t mk(int a_ms, int a_v, int a_br, int a_jmp, int a_jalr,
                                int a_rs1, int a_rs2, int a_exrd, int a_exw, int a_exm,
                                int a_memrd, int a_memw, int a_memm, int a_wbrd, int a_wbw,
                                int a_pcs, logic [31:0] a_tgt,
                                int x_st, int x_bub, int x_ld, int x_fl, int x_f1, int x_f2,
                                logic [31:0] x_tgt);
        vec_t r;
        r.ms = a_ms[0];   r.v = a_v[0];   r.br = a_br[0];   r.jmp = a_jmp[0];
        r.jalr = a_jalr[0];
        r.rs1 = a_rs1[4:0]; r.rs2 = a_rs2[4:0]; r.exrd = a_exrd[4:0];
        r.exw = a_exw[0]; r.exm = a_exm[0];
        r.memrd = a_memrd[4:0]; r.memw = a_memw[0]; r.memm = a_memm[0];
        r.wbrd = a_wbrd[4:0]; r.wbw = a_wbw[0]; r.pcs = a_pcs[0]; r.tgt = a_tgt;
        r.e_st = x_st[0]; r.e_bub = x_bub[0]; r.e_ld = x_ld[0]; r.e_fl = x_fl[0];
        r.e_f1 = x_f1[1:0]; r.e_f2 = x_f2[1:0]; r.e_tgt = x_tgt;
        return r;
    endfunction

    task automatic apply(input vec_t t);
        ms = t.ms; valid = t.v; br = t.br; jmp = t.jmp; jalr = t.jalr;
        rs1 = t.rs1; rs2 = t.rs2; exrd = t.exrd; exw = t.exw; exm = t.exm;
        memrd = t.memrd; memw = t.memw; memm = t.memm; wbrd = t.wbrd; wbw = t.wbw;
        pcs = t.pcs; tgt = t.tgt;
    endtask

    function automatic logic [40:0] obs();
        return {stall_if, stall_id, bubble, pc_load, flush, f1, f2, pc_target};
    endfunction

    function automatic logic [40:0] expv(input vec_t t);
        return {t.e_st, t.e_st, t.e_bub, t.e_ld, t.e_fl, t.e_f1, t.e_f2, t.e_tgt};
    endfunction

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] req);
        nvec++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Apply at posedge+1, compare at negedge, return at next posedge+1.
    task automatic step(input string name, input vec_t t);
        apply(t);
        @(negedge clk);
        check(name, obs(), expv(t));
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Table of single-cycle vectors; every entry leaves the FSM in RUN.
        tbl[0]  = mk(0,0,1,0,0, 5,0,   5,1,1,  0,0,0,  0,0,  1,32'h100, 0,0,0,0,0,0,32'h0);
        tbl[1]  = mk(0,1,1,0,0, 3,7,   0,0,0,  7,1,0,  7,1,  1,32'h200, 0,0,1,1,0,1,32'h200);
        tbl[2]  = mk(0,1,0,1,0, 1,0,   1,1,1,  0,0,0,  0,0,  1,32'h300, 0,0,1,1,0,0,32'h300);
        tbl[3]  = mk(0,1,0,1,1, 0,0,   0,1,0,  0,1,0,  0,0,  1,32'h400, 0,0,1,1,0,0,32'h400);
        tbl[4]  = mk(0,1,1,0,0, 4,6,   0,0,0,  6,1,1,  4,1,  0,32'h0,   1,1,0,0,2,0,32'h0);
        tbl[5]  = mk(0,1,1,0,0, 3,6,   6,1,0,  0,0,0,  0,0,  1,32'h500, 1,1,0,0,0,0,32'h0);
        tbl[6]  = mk(0,1,1,0,0, 9,10,  0,0,0,  9,1,0,  9,1,  0,32'h550, 0,0,0,0,1,0,32'h0);
        tbl[7]  = mk(0,1,0,1,1, 2,11,  11,1,0, 0,0,0,  11,1, 1,32'h600, 0,0,1,1,0,2,32'h600);
        tbl[8]  = mk(0,1,1,0,0, 12,0,  12,0,1, 0,0,0,  0,0,  1,32'h700, 0,0,1,1,0,0,32'h700);
        tbl[9]  = mk(0,0,0,0,0, 13,0,  0,0,0,  13,1,0, 0,0,  0,32'h0,   0,0,0,0,1,0,32'h0);
        tbl[10] = mk(1,1,0,1,0, 0,0,   0,0,0,  0,0,0,  0,0,  1,32'h800, 0,0,0,0,0,0,32'h0);
        tbl[11] = mk(1,1,1,0,0, 14,0,  14,1,0, 0,0,0,  0,0,  0,32'h0,   1,0,0,0,0,0,32'h0);
        tbl[12] = mk(0,1,1,0,0, 0,15,  0,0,0,  15,1,1, 15,1, 1,32'h900, 1,1,0,0,0,2,32'h0);

        // Reset: outputs must be 0 even with a taken JAL and a forwardable source.
        rst = 1'b1;
        apply(mk(0,1,0,1,0, 3,0, 0,0,0, 3,1,0, 0,0, 1,32'hABC, 0,0,0,0,0,0,32'h0));
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", obs(), 41'd0);
`ifdef BRANCH_PERF_CNT_EN
        check("reset_counters", {9'd0, br_cnt | tk_cnt | st_cnt}, 41'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // BEQ x5 behind an EX load: two stall cycles, then redirect.
        step("ld_stall_c1", mk(0,1,1,0,0, 5,0, 5,1,1, 0,0,0, 0,0, 1,32'h100, 1,1,0,0,0,0,32'h0));
        step("ld_stall_c2", mk(0,1,1,0,0, 5,0, 0,0,0, 5,1,1, 0,0, 1,32'h100, 1,1,0,0,0,0,32'h0));
        step("ld_redirect", mk(0,1,1,0,0, 5,0, 0,0,0, 0,0,0, 5,1, 1,32'h100, 0,0,1,1,2,0,32'h100));
        step("ld_after",    mk(0,0,1,0,0, 5,0, 0,0,0, 0,0,0, 5,1, 1,32'h100, 0,0,0,0,2,0,32'h0));

        // Reset in the first STALL cycle drops the pending stall.
        step("rst_stall_c1", mk(0,1,1,0,0, 5,0, 5,1,1, 0,0,0, 0,0, 1,32'h100, 1,1,0,0,0,0,32'h0));
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", obs(), 41'd0);
`ifdef BRANCH_PERF_CNT_EN
        check("rst_mid_counters", {9'd0, br_cnt | tk_cnt | st_cnt}, 41'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        step("rst_then_run", mk(0,1,1,0,0, 5,0, 0,0,0, 0,0,0, 0,0, 1,32'h700, 0,0,1,1,0,0,32'h700));

        // Freeze for 3 cycles while in STALL with cnt = 1.
`ifdef BRANCH_PERF_CNT_EN
        st_base = st_cnt;
        tk_base = tk_cnt;
`endif
        step("frz_c1", mk(0,1,1,0,0, 5,0, 5,1,1, 0,0,0, 0,0, 1,32'h800, 1,1,0,0,0,0,32'h0));
        for (int k = 0; k < 3; k++) begin
            step($sformatf("frz_hold%0d", k),
                 mk(1,1,1,0,0, 5,0, 5,1,1, 0,0,0, 0,0, 1,32'h800, 1,0,0,0,0,0,32'h0));
        end
        step("frz_release", mk(0,1,1,0,0, 5,0, 5,1,1, 0,0,0, 0,0, 1,32'h800, 1,1,0,0,0,0,32'h0));
`ifdef BRANCH_PERF_CNT_EN
        check("frz_stall_cycles", {9'd0, st_cnt - st_base}, 41'd2);
`endif
        step("frz_redirect", mk(0,1,1,0,0, 5,0, 0,0,0, 0,0,0, 5,1, 1,32'h800, 0,0,1,1,2,0,32'h800));
`ifdef BRANCH_PERF_CNT_EN
        check("frz_taken", {9'd0, tk_cnt - tk_base}, 41'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
